// File: rtl/host_cmd_pkg.sv
// Shared types and defaults for the host command front-end and the destination/reply side.
package host_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LEN,
        DATA
    } state_t;

    localparam logic [7:0] DEF_PREFIX = 8'hAA;
    localparam int         DEF_N_DEST = 10;

endpackage

// File: rtl/parser_timeout.sv
// Inter-byte gap counter: cleared by clr, counts while en, flags expire at TIMEOUT_CYCLES.
module parser_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign expire = en && !clr && (cnt == W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(TIMEOUT_CYCLES))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/host_cmd_parser.sv
// Frames host bytes into prefix/address/length/payload packets and strobes payload to one destination.
// Optional inter-byte timeout is enabled by defining PARSER_TIMEOUT_EN.
module host_cmd_parser
    import host_cmd_pkg::*;
#(
    parameter int         N_DEST         = DEF_N_DEST,
    parameter logic [7:0] PREFIX         = DEF_PREFIX,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        master_data,
    output logic [N_DEST-1:0] valid_bus,
    output logic              busy,
    output logic              pkt_err,
    output logic [7:0]        err_cnt
);

    state_t      state, state_nxt;
    logic [7:0]  dest, dest_nxt;
    logic [7:0]  remaining, remaining_nxt;
    logic        fwd;
    logic        err_now;
    logic        timeout;
    logic        dest_ok;
    logic [N_DEST-1:0] dest_onehot;

    assign busy        = (state != IDLE);
    assign dest_ok     = (32'(dest) < N_DEST);
    assign dest_onehot = {{(N_DEST-1){1'b0}}, 1'b1} << dest;

`ifdef PARSER_TIMEOUT_EN
    parser_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid || (state == IDLE)),
        .en     (state != IDLE),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        dest_nxt      = dest;
        remaining_nxt = remaining;
        fwd           = 1'b0;
        err_now       = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            err_now   = 1'b1;
        end else if (rx_valid) begin
            case (state)
                IDLE: if (rx_data == PREFIX) state_nxt = ADDR;
                ADDR: begin
                    dest_nxt  = rx_data;
                    state_nxt = LEN;
                end
                LEN: begin
                    if (rx_data == 8'd0) begin
                        err_now   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        remaining_nxt = rx_data;
                        state_nxt     = DATA;
                    end
                end
                DATA: begin
                    // PREFIX inside the payload is just data; no resync mid-packet.
                    fwd           = dest_ok;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_nxt = IDLE;
                        err_now   = !dest_ok;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dest        <= '0;
            remaining   <= '0;
            master_data <= '0;
            valid_bus   <= '0;
            pkt_err     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            dest      <= dest_nxt;
            remaining <= remaining_nxt;
            pkt_err   <= err_now;
            valid_bus <= fwd ? dest_onehot : '0;
            if (fwd) master_data <= rx_data;
            if (pkt_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Scoreboard bench for host_cmd_parser: expected strobes queued at drive time, checked at negedge.
module tb_host_cmd_parser;

    localparam int N_DEST = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        master_data;
    logic [N_DEST-1:0] valid_bus;
    logic              busy;
    logic              pkt_err;
    logic [7:0]        err_cnt;

    int vectors = 0;
    int errors  = 0;
    int exp_err = 0;
    int obs_err = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [N_DEST+7:0] sb_q[$];

    host_cmd_parser #(
        .N_DEST(N_DEST),
        .PREFIX(8'hAA),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .master_data (master_data),
        .valid_bus   (valid_bus),
        .busy        (busy),
        .pkt_err     (pkt_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (pkt_err) obs_err++;
        if (valid_bus != '0) begin
            logic [N_DEST+7:0] e;
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_spurious: got vb=%b md=%h, expected no strobe", valid_bus, master_data);
            end else begin
                e = sb_q.pop_front();
                if ({valid_bus, master_data} !== e) begin
                    errors++;
                    $display("FAIL strobe: got vb=%b md=%h, expected vb=%b md=%h",
                             valid_bus, master_data, e[N_DEST+7:8], e[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic note_err();
        exp_err++;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    // Full packet; payload byte i = b0 + i*step. Model decides forward vs error.
    task automatic send_pkt(input logic [7:0] d, input logic [7:0] l,
                            input logic [7:0] b0, input logic [7:0] step);
        logic [N_DEST-1:0] oh;
        logic [7:0] b;
        oh = '0;
        if (d < N_DEST) oh[d] = 1'b1;
        send(8'hAA);
        send(d);
        send(l);
        for (int i = 0; i < int'(l); i++) begin
            b = b0 + 8'(i) * step;
            if (d < N_DEST) sb_q.push_back({oh, b});
            send(b);
        end
        if (l == 8'd0 || d >= N_DEST) note_err();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_master_data", 32'(master_data), 0);
        chk("rst_valid_bus", 32'(valid_bus), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt_err", 32'(pkt_err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single();
        send(8'h55);                     // stray byte in IDLE: silently dropped
        chk("stray_busy", 32'(busy), 0);
        send(8'hAA);
        chk("prefix_busy", 32'(busy), 1);
        send(8'h00);
        send(8'h01);
        sb_q.push_back({10'b0000000001, 8'h05});
        send(8'h05);
        chk("single_busy_after", 32'(busy), 0);
        idle(2);
        chk("single_no_err", obs_err, exp_err);
        chk("single_master_hold", 32'(master_data), 32'h05);
    endtask

    task automatic test_back_to_back();
        send(8'hAA); send(8'h09); send(8'h03);
        sb_q.push_back({10'b1000000000, 8'h01}); send(8'h01);
        sb_q.push_back({10'b1000000000, 8'h02}); send(8'h02);
        chk("b2b_busy_mid", 32'(busy), 1);
        sb_q.push_back({10'b1000000000, 8'h03}); send(8'h03);
        chk("b2b_busy_end", 32'(busy), 0);
        idle(2);
        chk("b2b_no_err", obs_err, exp_err);
    endtask

    task automatic test_bad_dest();
        send_pkt(8'h0C, 8'd2, 8'h11, 8'h11);
        idle(3);
        chk("bad_dest_err_pulses", obs_err, exp_err);
        chk("bad_dest_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("bad_dest_busy", 32'(busy), 0);
    endtask

    task automatic test_prefix_payload();
        send_pkt(8'h03, 8'd0, 8'h00, 8'h00);
        send_pkt(8'h03, 8'd1, 8'hAA, 8'h00);   // immediately follows previous packet
        send_pkt(8'h07, 8'd4, 8'hA8, 8'h01);   // AA lands mid-payload
        idle(3);
        chk("len0_err_pulses", obs_err, exp_err);
        chk("len0_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("prefix_payload_drained", sb_q.size(), 0);
    endtask

`ifdef PARSER_TIMEOUT_EN
    task automatic test_timeout();
        send(8'hAA); send(8'h02); send(8'h04);
        sb_q.push_back({10'b0000000100, 8'h11}); send(8'h11);
        idle(20);
        note_err();
        chk("timeout_err_pulses", obs_err, exp_err);
        chk("timeout_busy", 32'(busy), 0);
        send_pkt(8'h02, 8'd1, 8'h33, 8'h00);
        idle(3);
        chk("timeout_recover", sb_q.size(), 0);
        chk("timeout_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    endtask
`endif

    task automatic test_mid_reset();
        send(8'hAA); send(8'h01); send(8'd10);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({10'b0000000010, 8'(8'h20 + i)});
            send(8'(8'h20 + i));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        chk("midrst_master_data", 32'(master_data), 0);
        chk("midrst_valid_bus", 32'(valid_bus), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pkt_err", 32'(pkt_err), 0);
        chk("midrst_err_cnt", 32'(err_cnt), 0);
        for (int i = 0; i < 7; i++) send(8'(8'h40 + i));  // leftover payload: dropped
        idle(3);
        chk("midrst_no_err", obs_err, exp_err);
        chk("midrst_busy_after", 32'(busy), 0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) send_pkt(8'h03, 8'd0, 8'h00, 8'h00);
        idle(3);
        chk("sat_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("sat_err_cnt_ff", 32'(err_cnt), 32'hFF);
        chk("sat_err_pulses", obs_err, exp_err);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_dest();
        test_prefix_payload();
`ifdef PARSER_TIMEOUT_EN
        test_timeout();
`endif
        test_mid_reset();
        test_saturate();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
